led_matrix_scan_driver: RTL and testbench

LED_MATRIX_SCAN_DRIVER -- requirements
Module: led_matrix_scan_driver

---
 rtl/led_matrix_scan_driver.sv | 94 +++++++++
 tb/tb_led_matrix_scan_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver: multiplexed row-scan driver for NUM_DIGITS LED matrices with a
// double-buffered frame store, frame-synchronous swap and per-row sampled PWM brightness.
module led_matrix_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int SCAN_DIV   = 1024,
    parameter int PWM_BITS   = 4,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [DW-1:0]              load_digit,
    input  logic [RW-1:0]              load_row,
    input  logic [COLS-1:0]            load_bits,
    input  logic                       commit,
    input  logic [PWM_BITS-1:0]        brightness,
    output logic [ROWS-1:0]            row_sel,
    output logic [NUM_DIGITS*COLS-1:0] col_data,
    output logic                       frame_start
);
    logic [COLS-1:0] bank_q [2][NUM_DIGITS][ROWS];
    logic [COLS-1:0] bank_d [2][NUM_DIGITS][ROWS];
    logic sel_q, sel_d, pend_q, pend_d, init_q, init_d, fb_q, fb_d;
    logic frame_start_q, frame_start_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [RW-1:0] r_q, r_d;
    logic [PWM_BITS-1:0] p_q, p_d, bright_q, bright_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic [NUM_DIGITS*COLS-1:0] col_data_q, col_data_d;
    logic tick, wrap, wr;

    assign load_ready  = !pend_q;
    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign frame_start = frame_start_q;

    always_comb begin
        tick     = pre_q == PW'(SCAN_DIV - 1);
        wrap     = tick && (r_q == RW'(ROWS - 1));
        wr       = load_valid && !pend_q;
        pre_d    = tick ? '0 : pre_q + PW'(1);
        r_d      = tick ? (wrap ? '0 : r_q + RW'(1)) : r_q;
        p_d      = p_q + PWM_BITS'(1);
        init_d   = 1'b0;
        // init_q marks the first clock after reset so brightness is captured then too
        bright_d = (tick || init_q) ? brightness : bright_q;
        pend_d   = (wrap && pend_q) ? 1'b0 : (commit && !pend_q) ? 1'b1 : pend_q;
        sel_d    = sel_q ^ (wrap && pend_q);
        fb_d     = wrap;
        bank_d   = bank_q;
        if (wr && (32'(load_digit) < NUM_DIGITS) && (32'(load_row) < ROWS))
            bank_d[!sel_q][load_digit][load_row] = load_bits;
        row_sel_d     = ROWS'(1) << r_q;
        frame_start_d = fb_q;
        col_data_d    = '0;
        for (int d = 0; d < NUM_DIGITS; d++)
            col_data_d[d*COLS +: COLS] = (p_q < bright_q) ? bank_q[sel_q][d][r_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q        <= '{default: '0};
            sel_q         <= 1'b0;
            pend_q        <= 1'b0;
            init_q        <= 1'b1;
            fb_q          <= 1'b0;
            pre_q         <= '0;
            r_q           <= '0;
            p_q           <= '0;
            bright_q      <= '0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            sel_q         <= sel_d;
            pend_q        <= pend_d;
            init_q        <= init_d;
            fb_q          <= fb_d;
            pre_q         <= pre_d;
            r_q           <= r_d;
            p_q           <= p_d;
            bright_q      <= bright_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb_led_matrix_scan_driver: directed bench for the scan driver with 2 digits, 8x8,
// 16 clocks per row and 2-bit PWM; k counts clock edges since the last reset release.
module tb_led_matrix_scan_driver;
    logic        clk = 1'b0, rst = 1'b1, load_valid = 1'b0, commit = 1'b0;
    logic        load_ready, frame_start;
    logic [0:0]  load_digit = '0;
    logic [2:0]  load_row = '0;
    logic [7:0]  load_bits = '0;
    logic [1:0]  brightness = 2'd3;
    logic [7:0]  row_sel;
    logic [15:0] col_data;
    int k = 0, total = 0, bad = 0;

    led_matrix_scan_driver #(
        .NUM_DIGITS(2), .ROWS(8), .COLS(8), .SCAN_DIV(16), .PWM_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_digit(load_digit), .load_row(load_row), .load_bits(load_bits),
        .commit(commit), .brightness(brightness), .row_sel(row_sel),
        .col_data(col_data), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    // row r is latched at edge 16*r (mod 128) and appears on row_sel one edge later
    task automatic scan_step();
        logic [7:0] er;
        step();
        er = 8'd1 << (((k - 1) / 16) % 8);
        check("row_sel", 32'(row_sel), 32'(er));
        check("frame_start", 32'(frame_start), 32'((k > 1) && ((k - 1) % 128 == 0)));
    endtask

    task automatic run_to(input int t);
        while (k < t) scan_step();
    endtask

    // PWM phase seen at output edge k is (k-1) mod 4; lit while that is below brightness
    task automatic win(input string tag, input int k0, input int k1, input logic [15:0] lit, input int b);
        run_to(k0 - 1);
        while (k < k1) begin
            scan_step();
            check(tag, 32'(col_data), ((k - 1) % 4 < b) ? 32'(lit) : 32'd0);
        end
    endtask

    task automatic write(input int d, input int r, input logic [7:0] bits, input logic c);
        load_valid = 1'b1;
        load_digit = 1'(d);
        load_row   = 3'(r);
        load_bits  = bits;
        commit     = c;
        scan_step();
        load_valid = 1'b0;
        commit     = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check("rst_row_sel", 32'(row_sel), 32'h0);
        check("rst_col_data", 32'(col_data), 32'h0);
        check("rst_load_ready", 32'(load_ready), 32'h1);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        rst = 1'b0;
        k = 0;
        win("dark_start", 1, 260, 16'h0000, 3);
        run_to(400);
        check("ready_idle", 32'(load_ready), 32'h1);
        write(0, 3, 8'hA5, 1'b0);
        win("f3_row3_hidden", 433, 448, 16'h0000, 3);
        run_to(470);
        commit = 1'b1;
        scan_step();
        commit = 1'b0;
        check("ready_pending", 32'(load_ready), 32'h0);
        run_to(475);
        write(1, 0, 8'hFF, 1'b1);
        check("ready_pending2", 32'(load_ready), 32'h0);
        run_to(511);
        check("ready_before_swap", 32'(load_ready), 32'h0);
        scan_step();
        check("ready_after_swap", 32'(load_ready), 32'h1);
        win("f4_row0_ignored", 513, 528, 16'h0000, 3);
        run_to(560);
        check("f4_row2", 32'(col_data), 32'h0);
        win("f4_row3", 561, 576, 16'h00A5, 3);
        win("f5_row3_no_reswap", 689, 704, 16'h00A5, 3);
        run_to(710);
        write(1, 6, 8'hFF, 1'b0);
        run_to(712);
        check("ready_before_wc", 32'(load_ready), 32'h1);
        write(1, 7, 8'h3C, 1'b1);
        check("ready_after_wc", 32'(load_ready), 32'h0);
        win("f6_row3", 817, 832, 16'h0000, 3);
        win("f6_row6", 865, 880, 16'hFF00, 3);
        win("f6_row7", 881, 896, 16'h3C00, 3);
        run_to(990);
        brightness = 2'd1;
        win("b1_row6a", 993, 1000, 16'hFF00, 1);
        brightness = 2'd3;
        win("b1_row6b", 1001, 1008, 16'hFF00, 1);
        win("b3_row7", 1009, 1024, 16'h3C00, 3);
        run_to(1030);
        brightness = 2'd0;
        win("b0_rows67", 1121, 1152, 16'h0000, 0);
        run_to(1155);
        brightness = 2'd3;
        run_to(1160);
        commit = 1'b1;
        scan_step();
        commit = 1'b0;
        check("ready_recommit", 32'(load_ready), 32'h0);
        win("f10_row3_old_front", 1329, 1344, 16'h00A5, 3);
        win("f10_row7", 1393, 1408, 16'h0000, 3);
        run_to(1420);
        commit = 1'b1;
        scan_step();
        commit = 1'b0;
        run_to(1430);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_row_sel", 32'(row_sel), 32'h0);
        check("mid_rst_col_data", 32'(col_data), 32'h0);
        check("mid_rst_load_ready", 32'(load_ready), 32'h1);
        check("mid_rst_frame_start", 32'(frame_start), 32'h0);
        step();
        step();
        check("held_rst_row_sel", 32'(row_sel), 32'h0);
        rst = 1'b0;
        k = 0;
        win("dark_after_rst", 1, 260, 16'h0000, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
